// File: rtl/dm_access_ctrl_pkg.sv
// Shared encodings and types for the load/store access controller.
package dm_access_ctrl_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANE_W = 2;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RMW_WR = 1'b1
   } state_e;

   // Context captured in the read cycle of a sub-word store.
   typedef struct packed {
      logic [LANE_W-1:0] lane;
      size_e             size;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] old_word;
   } rmw_ctx_t;

   function automatic logic is_bad_access(input size_e size, input logic [LANE_W-1:0] lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half lane handling: load extraction with extension, and store lane merge.
module dm_lane_align
   import dm_access_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] ld_word,
   input  logic [LANE_W-1:0] ld_lane,
   input  size_e             ld_size,
   input  logic              ld_unsigned,
   output logic [DATA_W-1:0] ld_data_c,
   input  logic [DATA_W-1:0] st_old,
   input  logic [DATA_W-1:0] st_data,
   input  logic [LANE_W-1:0] st_lane,
   input  size_e             st_size,
   output logic [DATA_W-1:0] st_word_c
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Load path: little-endian lane select, then sign or zero extension.
   always_comb begin
      ld_data_c = ld_word;
      ld_byte   = 8'h00;
      case (ld_lane)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      ld_half = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_size)
         SZ_BYTE: ld_data_c = ld_unsigned ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         SZ_HALF: ld_data_c = ld_unsigned ? {16'h0000, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data_c = ld_word;
      endcase
   end

   // Store path: replace only the addressed lane(s) of the old word.
   always_comb begin
      st_word_c = st_old;
      case (st_size)
         SZ_BYTE: begin
            case (st_lane)
               2'd0:    st_word_c[7:0]   = st_data[7:0];
               2'd1:    st_word_c[15:8]  = st_data[7:0];
               2'd2:    st_word_c[23:16] = st_data[7:0];
               default: st_word_c[31:24] = st_data[7:0];
            endcase
         end
         SZ_HALF: begin
            if (st_lane[1]) st_word_c[31:16] = st_data[15:0];
            else            st_word_c[15:0]  = st_data[15:0];
         end
         default: st_word_c = st_data;
      endcase
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store access controller: word-only data memory, sub-word stores via read-modify-write.
module dm_access_ctrl
   import dm_access_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_HI = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   input  logic                 req_wr,
   input  logic [1:0]           req_size,
   input  logic                 req_unsigned,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic [31:0]          rdata,
   output logic                 stall,
   output logic                 addr_err,
   output logic [ADDR_HI-2:0]   dm_addr,
   output logic [31:0]          dm_wdata,
   output logic                 dm_wr,
   output logic                 dm_rd,
   input  logic [31:0]          dm_rdata
);

   localparam int unsigned IDX_W = ADDR_HI - 1;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   rmw_ctx_t          ctx_q, ctx_d;

   size_e             req_size_e;
   logic [IDX_W-1:0]  req_idx;
   logic [DATA_W-1:0] ld_data_c;
   logic [DATA_W-1:0] st_word_c;
   logic              unused_addr_hi;

   assign req_size_e     = size_e'(req_size);
   assign req_idx        = req_addr[ADDR_HI:2];
   assign unused_addr_hi = ^req_addr[31:ADDR_HI+1];

   // Load extraction follows the live request; the store merge sees only latched context.
   dm_lane_align u_lane_align (
      .ld_word     (dm_rdata),
      .ld_lane     (req_addr[1:0]),
      .ld_size     (req_size_e),
      .ld_unsigned (req_unsigned),
      .ld_data_c   (ld_data_c),
      .st_old      (ctx_q.old_word),
      .st_data     (ctx_q.wdata),
      .st_lane     (ctx_q.lane),
      .st_size     (ctx_q.size),
      .st_word_c   (st_word_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ctx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ctx_q   <= ctx_d;
      end
   end

   // Next state and memory-side outputs; everything quiet while reset is held.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ctx_d    = ctx_q;
      rdata    = '0;
      stall    = 1'b0;
      addr_err = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      dm_wr    = 1'b0;
      dm_rd    = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  if (is_bad_access(req_size_e, req_addr[1:0])) begin
                     addr_err = 1'b1;
                  end else if (!req_wr) begin
                     dm_rd   = 1'b1;
                     dm_addr = req_idx;
                     rdata   = ld_data_c;
                  end else if (req_size_e == SZ_WORD) begin
                     dm_wr    = 1'b1;
                     dm_addr  = req_idx;
                     dm_wdata = req_wdata;
                  end else begin
                     dm_rd   = 1'b1;
                     dm_addr = req_idx;
                     stall   = 1'b1;
                     state_d = ST_RMW_WR;
                     idx_d   = req_idx;
                     ctx_d   = '{lane: req_addr[1:0], size: req_size_e,
                                 wdata: req_wdata, old_word: dm_rdata};
                  end
               end
            end
            ST_RMW_WR: begin
               dm_wr    = 1'b1;
               dm_addr  = idx_q;
               dm_wdata = st_word_c;
               state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed table, reset-in-RMW sequence, randomized traffic vs a memory model.
module tb_dm_access_ctrl;

   localparam int unsigned ADDR_HI   = 11;
   localparam int unsigned IDX_W     = ADDR_HI - 1;
   localparam int unsigned MEM_WORDS = 1 << IDX_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid, req_wr, req_unsigned;
   logic [1:0]        req_size;
   logic [31:0]       req_addr, req_wdata;
   logic [31:0]       rdata, dm_wdata, dm_rdata;
   logic              stall, addr_err, dm_wr, dm_rd;
   logic [IDX_W-1:0]  dm_addr;

   logic [31:0] mem     [MEM_WORDS];
   logic [31:0] ref_mem [MEM_WORDS];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_stall;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   assign dm_rdata = mem[dm_addr];
   always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_wdata;

   dm_access_ctrl #(.ADDR_HI(ADDR_HI)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .rdata(rdata), .stall(stall), .addr_err(addr_err), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_wr(dm_wr), .dm_rd(dm_rd), .dm_rdata(dm_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic model_err(input logic [1:0] size, input logic [1:0] lo);
      return (size == 2'b11) || (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
   endfunction

   function automatic int model_nbits(input logic [1:0] size);
      return (size == 2'b00) ? 8 : (size == 2'b01) ? 16 : 32;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lo);
      longint v;
      int     nb;
      nb = model_nbits(size);
      if (nb == 32) return w;
      v = longint'(w) >> (8 * lo);
      v = v % (longint'(1) << nb);
      if (!uns && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] size, input logic [1:0] lo);
      longint mask, nv;
      int     nb;
      nb   = model_nbits(size);
      mask = ((longint'(1) << nb) - 1) << (8 * lo);
      nv   = (longint'(old) & ~mask) | ((longint'(wd) << (8 * lo)) & mask);
      return 32'(nv);
   endfunction

   task automatic access(input logic wr, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] o_rdata, output logic o_err, output logic o_stall);
      int unsigned idx;
      logic        err;
      logic [31:0] exp_w;
      @(negedge clk);
      req_valid = 1'b1; req_wr = wr; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      #2;
      o_rdata = rdata; o_err = addr_err; o_stall = stall;
      idx = int'(addr[ADDR_HI:2]);
      err = model_err(size, addr[1:0]);
      chk("addr_err", 32'(addr_err), 32'(err));
      if (err) begin
         chk("err_dm_wr", 32'(dm_wr), 32'(0));
         chk("err_dm_rd", 32'(dm_rd), 32'(0));
         chk("err_stall", 32'(stall), 32'(0));
         chk("err_rdata", rdata, 32'h0);
      end else if (!wr) begin
         chk("ld_dm_rd", 32'(dm_rd), 32'(1));
         chk("ld_dm_wr", 32'(dm_wr), 32'(0));
         chk("ld_stall", 32'(stall), 32'(0));
         chk("ld_dm_addr", 32'(dm_addr), 32'(idx));
         chk("ld_rdata", rdata, model_load(ref_mem[idx], size, uns, addr[1:0]));
      end else if (size == 2'b10) begin
         chk("sw_dm_wr", 32'(dm_wr), 32'(1));
         chk("sw_dm_rd", 32'(dm_rd), 32'(0));
         chk("sw_stall", 32'(stall), 32'(0));
         chk("sw_dm_addr", 32'(dm_addr), 32'(idx));
         chk("sw_dm_wdata", dm_wdata, wd);
         ref_mem[idx] = wd;
      end else begin
         chk("rmw0_stall", 32'(stall), 32'(1));
         chk("rmw0_dm_wr", 32'(dm_wr), 32'(0));
         chk("rmw0_dm_rd", 32'(dm_rd), 32'(1));
         chk("rmw0_dm_addr", 32'(dm_addr), 32'(idx));
         exp_w = model_store(ref_mem[idx], wd, size, addr[1:0]);
         @(negedge clk);
         // Request inputs must be ignored while the merged word is written.
         req_valid = 1'($urandom); req_wr = 1'($urandom); req_size = 2'($urandom);
         req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         #2;
         chk("rmw1_dm_wr", 32'(dm_wr), 32'(1));
         chk("rmw1_dm_rd", 32'(dm_rd), 32'(0));
         chk("rmw1_stall", 32'(stall), 32'(0));
         chk("rmw1_dm_addr", 32'(dm_addr), 32'(idx));
         chk("rmw1_dm_wdata", dm_wdata, exp_w);
         ref_mem[idx] = exp_w;
      end
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      req_valid = 1'b0; req_wr = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      #2;
      chk("idle_dm_wr", 32'(dm_wr), 32'(0));
      chk("idle_dm_rd", 32'(dm_rd), 32'(0));
      chk("idle_stall", 32'(stall), 32'(0));
      chk("idle_rdata", rdata, 32'h0);
      chk("idle_addr_err", 32'(addr_err), 32'(0));
   endtask

   initial begin
      logic [31:0] o_r, old0;
      logic        o_e, o_s;
      logic [31:0] ra;

      rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      for (int i = 0; i < int'(MEM_WORDS); i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;

      // Reset state
      repeat (2) @(negedge clk);
      #2;
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_stall", 32'(stall), 32'(0));
      chk("rst_addr_err", 32'(addr_err), 32'(0));
      chk("rst_dm_addr", 32'(dm_addr), 32'(0));
      chk("rst_dm_wdata", dm_wdata, 32'h0);
      chk("rst_dm_wr", 32'(dm_wr), 32'(0));
      chk("rst_dm_rd", 32'(dm_rd), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      // wr size uns addr wdata exp_rdata exp_err exp_stall
      vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h5, 32'h0,        32'hFFFFFFAA, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h5, 32'h0,        32'h000000AA, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h6, 32'h0,        32'hFFFF8899, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h4, 32'h0,        32'h0000AABB, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h8899AABB, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h2, 32'h0,        32'h0,        1'b1, 1'b0});
      vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h3, 32'h1111,     32'h0,        1'b1, 1'b0});
      vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h4, 32'h0,        32'h0,        1'b1, 1'b0});
      vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h8, 32'h2222,     32'h0,        1'b1, 1'b0});
      vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h7, 32'h12,       32'h0,        1'b0, 1'b1});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h4, 32'h0,        32'h1299AABB, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h8, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 32'hB, 32'h0,        32'h000000DE, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h9, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 2'b01, 1'b0, 32'hA, 32'hAB1234,   32'h0,        1'b0, 1'b1});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h8, 32'h0,        32'h1234BEEF, 1'b0, 1'b0});

      foreach (vecs[i]) begin
         access(vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, o_r, o_e, o_s);
         chk($sformatf("tbl%0d_rdata", i), o_r, vecs[i].exp_rdata);
         chk($sformatf("tbl%0d_err", i), 32'(o_e), 32'(vecs[i].exp_err));
         chk($sformatf("tbl%0d_stall", i), 32'(o_s), 32'(vecs[i].exp_stall));
      end
      idle_cycle();

      // Reset while the merged half-word is being written: the store is dropped.
      old0 = ref_mem[0];
      @(negedge clk);
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h5566;
      #2;
      chk("rstrmw_c0_stall", 32'(stall), 32'(1));
      chk("rstrmw_c0_dm_wr", 32'(dm_wr), 32'(0));
      @(negedge clk);
      #2;
      chk("rstrmw_c1_dm_wr", 32'(dm_wr), 32'(1));
      rst = 1'b1;
      #1;
      chk("rstrmw_dm_wr_drop", 32'(dm_wr), 32'(0));
      chk("rstrmw_stall", 32'(stall), 32'(0));
      chk("rstrmw_dm_wdata", dm_wdata, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b0;
      #2;
      chk("rstrmw_mem0", mem[0], old0);
      chk("rstrmw_post_dm_wr", 32'(dm_wr), 32'(0));
      chk("rstrmw_post_dm_addr", 32'(dm_addr), 32'(0));
      access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, o_r, o_e, o_s);
      chk("rstrmw_idle_stall", 32'(o_s), 32'(0));
      chk("rstrmw_lw0", o_r, old0);

      // Randomized traffic over a few words, upper address bits scrambled.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            idle_cycle();
         end else begin
            ra = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                 | 32'($urandom_range(0, 3));
            access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom, o_r, o_e, o_s);
         end
      end
      idle_cycle();

      for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
